// File: rtl/pixel_job_scheduler.sv
// Pixel job scheduler: walks a frame in raster order and hands one pixel job per
// transfer to a set of ray-tracing cores in strict round-robin order.
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   start                 one-cycle request to render one frame
//   image_width/height    frame dimensions in pixels (latched at start)
//   no_of_extra_cores     active cores minus one (clamped to MAX_CORES-1)
//   job_ready             per-core ready
//   job_valid             per-core job offer, one-hot or zero
//   job_index/job_x/job_y 1-based raster index and 0-based column/row of the offer
//   busy                  high while a frame is in progress
//   frame_done            one-cycle pulse after the last job is accepted
//   cfg_error             one-cycle pulse when start is rejected for a zero dimension
module pixel_job_scheduler #(
    parameter int unsigned MAX_CORES = 2,
    parameter int unsigned IDX_W     = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [12:0]          image_width,
    input  logic [12:0]          image_height,
    input  logic [1:0]           no_of_extra_cores,
    input  logic [MAX_CORES-1:0] job_ready,
    output logic [MAX_CORES-1:0] job_valid,
    output logic [IDX_W-1:0]     job_index,
    output logic [12:0]          job_x,
    output logic [12:0]          job_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_error
);

    localparam int unsigned CoreW = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [12:0]        width_q, width_d;
    logic [CoreW-1:0]   n_active_q, n_active_d;
    logic [CoreW-1:0]   core_q, core_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   total_q, total_d;
    logic [12:0]        x_q, x_d;
    logic [12:0]        y_q, y_d;
    logic               cfg_error_q, cfg_error_d;

    logic [25:0]        frame_pixels;
    logic               transfer;

    assign frame_pixels = image_width * image_height;

    // Only the selected core's ready matters; the others are ignored.
    assign transfer = (state_q == StDispatch) && job_ready[core_q];

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        n_active_d  = n_active_q;
        core_d      = core_q;
        index_d     = index_q;
        total_d     = total_q;
        x_d         = x_q;
        y_d         = y_q;
        cfg_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ((image_width != 13'd0) && (image_height != 13'd0)) begin
                        width_d = image_width;
                        if (32'(no_of_extra_cores) > (MAX_CORES - 1)) begin
                            n_active_d = CoreW'(MAX_CORES - 1);
                        end else begin
                            n_active_d = CoreW'(no_of_extra_cores);
                        end
                        // Height is only needed through the total pixel count.
                        total_d = IDX_W'(frame_pixels);
                        index_d = IDX_W'(1);
                        x_d     = 13'd0;
                        y_d     = 13'd0;
                        core_d  = '0;
                        state_d = StDispatch;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            StDispatch: begin
                if (transfer) begin
                    if (index_q == total_q) begin
                        // Last job accepted: hold the final job's coordinates.
                        state_d = StDone;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        if (x_q == width_q - 13'd1) begin
                            x_d = 13'd0;
                            y_d = y_q + 13'd1;
                        end else begin
                            x_d = x_q + 13'd1;
                        end
                        if (core_q == n_active_q) begin
                            core_d = '0;
                        end else begin
                            core_d = core_q + CoreW'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            width_q     <= 13'd0;
            n_active_q  <= '0;
            core_q      <= '0;
            index_q     <= '0;
            total_q     <= '0;
            x_q         <= 13'd0;
            y_q         <= 13'd0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            n_active_q  <= n_active_d;
            core_q      <= core_d;
            index_q     <= index_d;
            total_q     <= total_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    always_comb begin
        job_valid = '0;
        if (state_q == StDispatch) begin
            job_valid[core_q] = 1'b1;
        end
    end

    assign job_index  = index_q;
    assign job_x      = x_q;
    assign job_y      = y_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_pixel_job_scheduler.sv
module tb_pixel_job_scheduler;

    localparam int unsigned MAX_CORES = 2;
    localparam int unsigned IDX_W     = 32;

    logic                 aclk;
    logic                 aresetn;
    logic                 start;
    logic [12:0]          image_width;
    logic [12:0]          image_height;
    logic [1:0]           no_of_extra_cores;
    logic [MAX_CORES-1:0] job_ready;
    logic [MAX_CORES-1:0] job_valid;
    logic [IDX_W-1:0]     job_index;
    logic [12:0]          job_x;
    logic [12:0]          job_y;
    logic                 busy;
    logic                 frame_done;
    logic                 cfg_error;

    int n_checks = 0;
    int n_errors = 0;

    pixel_job_scheduler #(
        .MAX_CORES(MAX_CORES),
        .IDX_W    (IDX_W)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .start            (start),
        .image_width      (image_width),
        .image_height     (image_height),
        .no_of_extra_cores(no_of_extra_cores),
        .job_ready        (job_ready),
        .job_valid        (job_valid),
        .job_index        (job_index),
        .job_x            (job_x),
        .job_y            (job_y),
        .busy             (busy),
        .frame_done       (frame_done),
        .cfg_error        (cfg_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected job k of a frame of width w with ncores round-robin cores.
    task automatic check_job(input string tag, input int k, input int w, input int ncores);
        check({tag, " valid"}, 64'(job_valid), 64'(1 << ((k - 1) % ncores)));
        check({tag, " index"}, 64'(job_index), 64'(k));
        check({tag, " x"},     64'(job_x),     64'((k - 1) % w));
        check({tag, " y"},     64'(job_y),     64'((k - 1) / w));
    endtask

    task automatic start_frame(input int w, input int h, input int extra);
        image_width       = 13'(w);
        image_height      = 13'(h);
        no_of_extra_cores = 2'(extra);
        start             = 1'b1;
        tick();
        start             = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, " frame_done"}, 64'(frame_done), 64'd1);
        check({tag, " valid_off"},  64'(job_valid),  64'd0);
        tick();
        check({tag, " done_pulse"}, 64'(frame_done), 64'd0);
        check({tag, " idle"},       64'(busy),       64'd0);
    endtask

    initial begin
        aresetn           = 1'b0;
        start             = 1'b0;
        image_width       = 13'd0;
        image_height      = 13'd0;
        no_of_extra_cores = 2'd0;
        job_ready         = 2'b11;
        tick();
        tick();

        // Reset state
        check("rst valid",      64'(job_valid),  64'd0);
        check("rst index",      64'(job_index),  64'd0);
        check("rst x",          64'(job_x),      64'd0);
        check("rst y",          64'(job_y),      64'd0);
        check("rst busy",       64'(busy),       64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);
        check("rst cfg_error",  64'(cfg_error),  64'd0);
        aresetn = 1'b1;
        tick();

        // 4x2 frame, two cores, always ready: one job per cycle
        start_frame(4, 2, 1);
        check("f1 busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            check_job("f1", k, 4, 2);
            tick();
        end
        check_done("f1");

        // Core 1 stalls at index 2: offer held, core 0 gets nothing
        job_ready = 2'b01;
        start_frame(4, 2, 1);
        check_job("f2", 1, 4, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("f2 stall valid", 64'(job_valid), 64'h2);
            check("f2 stall index", 64'(job_index), 64'd2);
            check("f2 stall x",     64'(job_x),     64'd1);
            tick();
        end
        job_ready = 2'b11;
        for (int k = 2; k <= 8; k++) begin
            check_job("f2", k, 4, 2);
            tick();
        end
        check_done("f2");

        // extra=3 clamped to two cores; 3x1 frame -> cores 0,1,0
        start_frame(3, 1, 3);
        for (int k = 1; k <= 3; k++) begin
            check_job("f3", k, 3, 2);
            tick();
        end
        check_done("f3");

        // Zero width and zero height are rejected
        start_frame(0, 5, 1);
        check("z0 cfg_error", 64'(cfg_error), 64'd1);
        check("z0 busy",      64'(busy),      64'd0);
        check("z0 valid",     64'(job_valid), 64'd0);
        tick();
        check("z0 cfg_pulse", 64'(cfg_error), 64'd0);
        check("z0 busy2",     64'(busy),      64'd0);
        start_frame(4, 0, 1);
        check("z1 cfg_error", 64'(cfg_error), 64'd1);
        check("z1 busy",      64'(busy),      64'd0);
        tick();

        // Start mid-frame with different dimensions is ignored
        start_frame(4, 2, 1);
        for (int k = 1; k <= 8; k++) begin
            check_job("f4", k, 4, 2);
            if (k == 3) begin
                image_width  = 13'd2;
                image_height = 13'd7;
                start        = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check_done("f4");
        tick();
        check("f4 single_done", 64'(frame_done), 64'd0);

        // Reset at index 5 abandons the frame
        start_frame(4, 2, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        check_job("f5 pre", 5, 4, 2);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("f5 rst valid", 64'(job_valid),  64'd0);
        check("f5 rst index", 64'(job_index),  64'd0);
        check("f5 rst x",     64'(job_x),      64'd0);
        check("f5 rst y",     64'(job_y),      64'd0);
        check("f5 rst busy",  64'(busy),       64'd0);
        check("f5 rst done",  64'(frame_done), 64'd0);
        tick();
        check("f5 no_done",   64'(frame_done), 64'd0);
        start_frame(4, 2, 1);
        check_job("f5 restart", 1, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
